// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch stage and control_unit.
//   - Datapath widths and the post-reset fetch address.
//   - Instruction field positions (opcode, function code).
//   - Fetch FSM state encoding.
//   - Opcode values decoded by control_unit.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: one-entry valid/ready holding register between fetch and decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop any held entry (branch/jump redirect); wins over load
//   load            capture load_instr/load_pc and raise out_valid
//   out_ready       downstream accepts; valid & ready with no load empties the slot
//   out_valid/out_instr/out_pc   registered outputs, stable while stalled
module fetch_out_reg #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= load_instr;
            out_pc    <= load_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 16-bit CPU.
// Holds the PC, issues one outstanding request at a time to instruction
// memory, and parks the returned word in a one-entry register feeding decode.
// A redirect (taken beq/bne or jmp) reloads the PC, flushes the output slot
// and marks any in-flight response for discard.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt   request handshake; addr held until granted
//   imem_rvalid/imem_rdata        read return, at least one cycle after grant
//   redirect_valid/redirect_pc    one-cycle redirect pulse and target
//   out_valid/out_ready/out_instr/out_pc   valid/ready output to decode
//   opcode/function_code          instruction fields for control_unit
// Build option INSTR_FETCH_STATS_EN adds saturating counters:
//   stat_fetched  accepted output transfers
//   stat_dropped  discarded responses plus flushed valid outputs
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [3:0]         opcode,
    output logic [3:0]         function_code
`ifdef INSTR_FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_dropped
`endif
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic            load;
    logic            slot_free;

    assign slot_free = !out_valid || out_ready;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        load       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A redirect here only retargets the PC; request next cycle.
                if (!redirect_valid && slot_free) state_d = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    // Granted request is in flight even if redirected now.
                    state_d    = WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_W'(1);
                    drop_d     = redirect_valid;
                end else if (redirect_valid) begin
                    // Drop req for a cycle so the new address is presented fresh.
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redirect_valid) begin
                        state_d = IDLE;
                    end else begin
                        load    = 1'b1;
                        state_d = out_ready ? REQ : IDLE;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc;
    end

    fetch_out_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .load       (load),
        .load_instr (imem_rdata),
        .load_pc    (req_pc_q),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    assign opcode        = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign function_code = out_instr[FUNCT_MSB:FUNCT_LSB];

`ifdef INSTR_FETCH_STATS_EN
    logic        xfer;
    logic        drop_resp;
    logic        flush_valid;
    logic [1:0]  drop_inc;
    logic [32:0] fetched_sum;
    logic [32:0] dropped_sum;

    // A flushed entry is not an accepted transfer even if out_ready was high.
    assign xfer        = out_valid && out_ready && !redirect_valid;
    assign drop_resp   = (state_q == WAIT) && imem_rvalid && (drop_q || redirect_valid);
    assign flush_valid = redirect_valid && out_valid;
    assign drop_inc    = 2'(drop_resp) + 2'(flush_valid);
    assign fetched_sum = {1'b0, stat_fetched} + 33'(xfer);
    assign dropped_sum = {1'b0, stat_dropped} + 33'(drop_inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            stat_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses and expected
// decode transfers are queued when each scenario is set up and popped as the
// DUT grants requests / hands instructions to decode.
module tb_instr_fetch;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [15:0] out_instr, out_pc;
    logic [3:0]  opcode, function_code;

    logic        w_req, w_gnt, w_rvalid, w_out_valid;
    logic [15:0] w_addr, w_rdata, w_out_instr, w_out_pc;
    logic [3:0]  w_opcode, w_function_code;
`ifdef INSTR_FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_dropped, w_stat_fetched, w_stat_dropped;
`endif

    logic [15:0] mem [0:255];
    logic        gnt_en, mem_clr, mon_en, w_cap;
    logic [15:0] slow_addr;
    int          pend_cnt;
    logic [15:0] pend_data;
    int          cyc, req_cyc, val_cyc;
    bit          req_seen, val_seen, saw_forbidden;
    exp_t        out_q[$];
    logic [15:0] addr_q[$];
    int          xfer_cyc[$];
    logic [31:0] w_log[$];
    logic        w_pend;
    logic [15:0] w_pdata;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode), .function_code(function_code)
`ifdef INSTR_FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped)
`endif
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc),
        .opcode(w_opcode), .function_code(w_function_code)
`ifdef INSTR_FETCH_STATS_EN
        , .stat_fetched(w_stat_fetched), .stat_dropped(w_stat_dropped)
`endif
    );

    assign imem_gnt = imem_req & gnt_en;
    assign w_gnt    = w_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model + output monitor; all sampling at negedge, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        imem_rvalid = 1'b0;
        if (mem_clr) begin
            pend_cnt      = 0;
            req_seen      = 0;
            val_seen      = 0;
            saw_forbidden = 0;
        end else begin
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_data;
                end
            end
            if (imem_req && imem_gnt) begin
                if (addr_q.size() > 0) chk("imem_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
                pend_data = mem[imem_addr[7:0]];
                pend_cnt  = (imem_addr == slow_addr) ? 3 : 1;
            end
            if (imem_req && !req_seen) begin req_seen = 1; req_cyc = cyc; end
            if (out_valid && !val_seen) begin val_seen = 1; val_cyc = cyc; end
        end
        if (out_valid && out_instr == 16'h6FFF) saw_forbidden = 1;
        if (mon_en && out_valid && out_ready && !redirect_valid) begin
            chk("xfer_expected", 32'(out_q.size() > 0), 32'd1);
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("out_pc", 32'(out_pc), 32'(e.pc));
                chk("out_instr", 32'(out_instr), 32'(e.instr));
                chk("opcode", 32'(opcode), 32'(e.instr[15:12]));
                chk("function_code", 32'(function_code), 32'(e.instr[3:0]));
                xfer_cyc.push_back(cyc);
            end
        end
    end

    // Fixed 1-cycle memory for the wrap instance.
    always @(negedge clk) begin
        w_rvalid = w_pend;
        w_rdata  = w_pdata;
        w_pend   = w_req;
        w_pdata  = w_addr ^ 16'h5A5A;
        if (w_cap && w_out_valid) w_log.push_back({w_out_pc, w_out_instr});
    end

    task automatic do_reset(input logic rdy, input logic gnt);
        rst            = 1'b1;
        mem_clr        = 1'b1;
        mon_en         = 1'b0;
        redirect_valid = 1'b0;
        gnt_en         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_q.delete();
        addr_q.delete();
        xfer_cyc.delete();
        slow_addr = 16'hFFFF;
        out_ready = rdy;
        gnt_en    = gnt;
        mem_clr   = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic wait_outq(input string tag);
        int n = 0;
        while (out_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_outq_drained"}, 32'(out_q.size()), 32'd0);
    endtask

    task automatic wait_grant(input string tag, input logic [15:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && imem_gnt && imem_addr == a) && n < 100);
        chk({tag, "_grant_seen"}, 32'(imem_req && imem_gnt && imem_addr == a), 32'd1);
    endtask

    initial begin
        bit vflag;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = {4'h7, i[7:0], 4'h3};
        mem[0] = 16'h0012;
        mem[1] = 16'h1345;
        mem[2] = 16'h2678;
        mem[4] = 16'h6FFF;
        cyc = 0; rst = 1'b1; gnt_en = 1'b0; out_ready = 1'b0; mon_en = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; mem_clr = 1'b1; w_cap = 1'b0;
        slow_addr = 16'hFFFF; imem_rdata = '0; w_pend = 0; w_pdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_instr", 32'(out_instr), 0);
        chk("rst_out_pc", 32'(out_pc), 0);
        chk("rst_wrap_addr", 32'(w_addr), 32'hFFFF);

        // Streaming fetch, 1-cycle memory, decode always ready
        @(posedge clk); #1;
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(16'(i));
            out_q.push_back('{pc: 16'(i), instr: mem[i]});
        end
        mon_en = 1'b1;
        wait_outq("p1");
        mon_en = 1'b0;
        chk("p1_addrq", 32'(addr_q.size()), 0);
        chk("p1_latency", 32'(val_cyc - req_cyc), 2);
        if (xfer_cyc.size() == 3) begin
            chk("p1_rate01", 32'(xfer_cyc[1] - xfer_cyc[0]), 2);
            chk("p1_rate12", 32'(xfer_cyc[2] - xfer_cyc[1]), 2);
        end

        // Backpressure from decode
        do_reset(1'b0, 1'b1);
        out_q.push_back('{pc: 16'h0000, instr: mem[0]});
        mon_en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("p2_first_valid", 32'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("p2_hold_valid", 32'(out_valid), 1);
            chk("p2_hold_pc", 32'(out_pc), 0);
            chk("p2_hold_instr", 32'(out_instr), 32'(mem[0]));
            chk("p2_no_req", 32'(imem_req), 0);
        end
        @(posedge clk); #1;
        addr_q.push_back(16'h0001);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("p2_req_after_ready", 32'(imem_req), 1);
        chk("p2_addr_after_ready", 32'(imem_addr), 1);
        wait_outq("p2");
        chk("p2_addrq", 32'(addr_q.size()), 0);

        // Redirect while waiting on a slow response
        do_reset(1'b1, 1'b1);
        slow_addr = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(16'(i));
            out_q.push_back('{pc: 16'(i), instr: mem[i]});
        end
        addr_q.push_back(16'h0004);
        addr_q.push_back(16'h0040);
        out_q.push_back('{pc: 16'h0040, instr: mem[8'h40]});
        mon_en = 1'b1;
        wait_grant("p3", 16'h0004);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_outq("p3");
        chk("p3_no_6fff", 32'(saw_forbidden), 0);
        chk("p3_addrq", 32'(addr_q.size()), 0);

        // Redirect in the same cycle as the grant
        do_reset(1'b1, 1'b0);
        addr_q.push_back(16'h0000);
        addr_q.push_back(16'h0050);
        out_q.push_back('{pc: 16'h0050, instr: mem[8'h50]});
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gnt_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0050;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_outq("p4a");
        chk("p4a_addrq", 32'(addr_q.size()), 0);
`ifdef INSTR_FETCH_STATS_EN
        @(negedge clk);
        chk("p4a_stat_fetched", stat_fetched, 1);
        chk("p4a_stat_dropped", stat_dropped, 1);
        @(posedge clk); #1;
`endif

        // Redirect in the same cycle as rvalid
        do_reset(1'b1, 1'b1);
        addr_q.push_back(16'h0000);
        addr_q.push_back(16'h0060);
        out_q.push_back('{pc: 16'h0060, instr: mem[8'h60]});
        mon_en = 1'b1;
        wait_grant("p4b", 16'h0000);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 16'h0060;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_outq("p4b");
        chk("p4b_addrq", 32'(addr_q.size()), 0);

        // PC wrap from 0xFFFF on the second instance
        do_reset(1'b1, 1'b1);
        w_cap = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        w_cap = 1'b0;
        chk("wrap_count", 32'(w_log.size() >= 2), 1);
        if (w_log.size() >= 2) begin
            chk("wrap_first", w_log[0], {16'hFFFF, 16'hFFFF ^ 16'h5A5A});
            chk("wrap_second", w_log[1], {16'h0000, 16'h5A5A});
        end

        // Reset while in WAIT, response arrives afterwards
        do_reset(1'b1, 1'b1);
        slow_addr = 16'h0000;
        wait_grant("p6", 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1; gnt_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("p6_out_valid", 32'(out_valid), 0);
        chk("p6_imem_req", 32'(imem_req), 0);
`ifdef INSTR_FETCH_STATS_EN
        chk("p6_stat_fetched", stat_fetched, 0);
        chk("p6_stat_dropped", stat_dropped, 0);
`endif
        vflag = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) vflag = 1;
        end
        chk("p6_no_valid", 32'(vflag), 0);
        chk("p6_req", 32'(imem_req), 1);
        chk("p6_addr", 32'(imem_addr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
